// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART rx and tx engines.
//   rx_state_t          - receive FSM states
//   MAX_BITS            - widest frame payload: 8 data bits plus parity
//   SYNC_STAGES_DEFAULT - default depth of the rx input synchroniser
//   parity_sense_t      - parity sense encoding on the ohel input (EVEN=0, ODD=1)
//   frame_bits()        - payload bits per frame for a given config
//   parity_error()      - parity check over the received payload
//   maj3()              - 2-of-3 vote, used by the majority-sampling build
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} parity_sense_t;

  localparam int MAX_BITS            = 9;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Data bits plus optional parity bit; the stop bit is handled on its own.
  function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
    return (eight ? 4'd8 : 4'd7) + {3'b000, pen};
  endfunction

  // Unused payload positions are held at zero, so XOR over the whole
  // vector equals XOR over the received data and parity bits.
  function automatic logic parity_error(input logic [MAX_BITS-1:0] bits,
                                        input logic                en,
                                        input parity_sense_t       sense);
    return en & ((^bits) ^ (sense == ODD));
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_baud_timer.sv
// rx_baud_timer: loadable down-counter that paces the receive sampling.
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   load_half - load k>>1 (half-bit delay to the middle of the start bit)
//   load_full - load a full bit time; takes priority below load_half
//   k         - clocks per bit time
//   tick      - high while the counter sits at zero (sample point)
module rx_baud_timer #(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_half,
  input  logic          load_full,
  input  logic [KW-1:0] k,
  output logic          tick
);

  logic [KW-1:0] cnt_reg;

  // A full load is k-1 because the zero count itself occupies one clock,
  // so consecutive ticks are exactly k clocks apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load_half) begin
      cnt_reg <= k >> 1;
    end else if (load_full) begin
      cnt_reg <= k - KW'(1);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - KW'(1);
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/rx_engine.sv
// rx_engine: UART receive engine.
// Synchronises rx, qualifies the start bit at mid-bit, shifts in 7/8 data
// bits LSB-first with optional parity, checks the stop bit and posts the
// character with sticky rxrdy/perr/ferr/ovf flags cleared by read.
//   clk     - system clock             reset - async active-low reset
//   rx      - serial input (idle high) k     - clocks per bit (>= 4)
//   eight   - 8 data bits (else 7)     pen   - parity enable
//   ohel    - parity sense (0 even, 1 odd)
//   read    - host read strobe, clears the status flags
//   rx_data - received character       rxrdy - character available
//   perr    - parity error             ferr  - framing error
//   ovf     - overrun
// Build option: define RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling
// around each sample point (adds one clock to the frame latency).
module rx_engine
  import uart_pkg::*;
#(
  parameter int KW          = 19,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic [KW-1:0] k,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  input  logic          read,
  output logic [7:0]    rx_data,
  output logic          rxrdy,
  output logic          perr,
  output logic          ferr,
  output logic          ovf
);

  // ---------------- input synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_reg <= '1;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_reg[SYNC_STAGES-1];

  // ---------------- state and frame config ----------------
  rx_state_t             state_reg, state_next;
  logic [KW-1:0]         k_reg;
  logic                  eight_reg, pen_reg, ohel_reg;
  logic [3:0]            bit_cnt_reg;
  logic [MAX_BITS-1:0]   data_reg;
  logic                  armed_reg;
  logic                  done;

  // ---------------- baud timer ----------------
  logic          tick;
  logic          load_half, load_full;
  logic [KW-1:0] timer_k;

  // Live k is only used for the half-bit load while idle; the frame runs
  // on the value latched at the start edge.
  assign load_half = (state_reg == IDLE);
  assign load_full = (state_reg != IDLE) && tick;
  assign timer_k   = (state_reg == IDLE) ? k : k_reg;

  rx_baud_timer #(.KW(KW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_half (load_half),
    .load_full (load_full),
    .k         (timer_k),
    .tick      (tick)
  );

  // ---------------- sample point ----------------
  logic sample_valid;
  logic sample_bit;

`ifdef RX_MAJORITY_VOTE_EN
  // Vote over rxs at count 1, count 0 and the clock after. The timer has
  // already reloaded at count 0, so deciding one clock late causes no drift.
  logic rxs_d1_reg, rxs_d2_reg, tick_d_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxs_d1_reg <= 1'b1;
      rxs_d2_reg <= 1'b1;
      tick_d_reg <= 1'b0;
    end else begin
      rxs_d1_reg <= rxs;
      rxs_d2_reg <= rxs_d1_reg;
      tick_d_reg <= tick && (state_reg != IDLE);
    end
  end

  assign sample_valid = tick_d_reg && (state_reg != IDLE);
  assign sample_bit   = maj3(rxs_d2_reg, rxs_d1_reg, rxs);
`else
  assign sample_valid = tick && (state_reg != IDLE);
  assign sample_bit   = rxs;
`endif

  // ---------------- FSM ----------------
  logic [3:0] last_bit;
  assign last_bit = frame_bits(eight_reg, pen_reg) - 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        // armed_reg blocks re-triggering on a line still held low after a
        // framing error (break) until it has been seen high again.
        if (!rxs && armed_reg) state_next = START;
      end
      START: begin
        if (sample_valid) state_next = sample_bit ? IDLE : DATA;
      end
      DATA: begin
        if (sample_valid && (bit_cnt_reg == last_bit)) state_next = STOP;
      end
      STOP: begin
        if (sample_valid) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg       <= '0;
      eight_reg   <= 1'b0;
      pen_reg     <= 1'b0;
      ohel_reg    <= 1'b0;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      armed_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        bit_cnt_reg <= '0;
        data_reg    <= '0;
        if (state_next == START) begin
          k_reg     <= k;
          eight_reg <= eight;
          pen_reg   <= pen;
          ohel_reg  <= ohel;
        end
      end else if ((state_reg == DATA) && sample_valid) begin
        data_reg[bit_cnt_reg] <= sample_bit;
        bit_cnt_reg           <= bit_cnt_reg + 4'd1;
      end

      if (done && !sample_bit) armed_reg <= 1'b0;
      else if (rxs)            armed_reg <= 1'b1;
    end
  end

  // ---------------- host-side flags ----------------
  logic [7:0] rx_data_reg;
  logic       rxrdy_reg, perr_reg, ferr_reg, ovf_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_reg <= '0;
      rxrdy_reg   <= 1'b0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else if (done) begin
      // A completing character wins over a coincident read.
      rx_data_reg <= eight_reg ? data_reg[7:0] : {1'b0, data_reg[6:0]};
      rxrdy_reg   <= 1'b1;
      ferr_reg    <= ~sample_bit;
      perr_reg    <= parity_error(data_reg, pen_reg, parity_sense_t'(ohel_reg));
      if (read)           ovf_reg <= 1'b0;
      else if (rxrdy_reg) ovf_reg <= 1'b1;
    end else if (read) begin
      rxrdy_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end
  end

  assign rx_data = rx_data_reg;
  assign rxrdy   = rxrdy_reg;
  assign perr    = perr_reg;
  assign ferr    = ferr_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_rx_engine.sv
// tb_rx_engine: self-checking bench for rx_engine. Directed frames cover
// reset, latency, parity, framing, break, overrun, glitch and mid-frame
// reset; a randomized section drives frames with random config and
// corruption against a frame-level model of the host-visible flags.
module tb_rx_engine;

  localparam int KW   = 19;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic [KW-1:0] k;
  logic          eight, pen, ohel, read;
  logic [7:0]    rx_data;
  logic          rxrdy, perr, ferr, ovf;

  always #5 clk = ~clk;

  rx_engine #(.KW(KW), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .k       (k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .read    (read),
    .rx_data (rx_data),
    .rxrdy   (rxrdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model of host-visible state ----------------
  logic [7:0] m_data;
  logic       m_rdy, m_perr, m_ferr, m_ovf;

  task automatic model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_char(input logic [7:0] d, input logic pe, input logic fe);
    if (m_rdy) m_ovf = 1'b1;
    m_rdy = 1'b1; m_data = d; m_perr = pe; m_ferr = fe;
  endtask

  task automatic model_read();
    m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    check({tag, "_data"},  {24'h0, rx_data}, {24'h0, m_data});
    check({tag, "_rxrdy"}, {31'h0, rxrdy},   {31'h0, m_rdy});
    check({tag, "_perr"},  {31'h0, perr},    {31'h0, m_perr});
    check({tag, "_ferr"},  {31'h0, ferr},    {31'h0, m_ferr});
    check({tag, "_ovf"},   {31'h0, ovf},     {31'h0, m_ovf});
  endtask

  // ---------------- stimulus helpers (drive just after posedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    model_read();
  endtask

  // Holds one bit for kk clocks; optionally inverts rx for the single clock
  // edge at offset spike_ofs into the bit.
  task automatic drive_bit(input logic b, input int kk, input int spike_ofs);
    rx = b;
    if (spike_ofs > 0) begin
      repeat (spike_ofs - 1) @(posedge clk);
      #1 rx = ~b;
      @(posedge clk);
      #1 rx = b;
      repeat (kk - spike_ofs) @(posedge clk);
    end else begin
      repeat (kk) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nd, input logic use_par,
                            input logic par_bit, input logic stop_bit, input int kk,
                            input int spike_ofs);
    drive_bit(1'b0, kk, 0);
    for (int i = 0; i < nd; i++) drive_bit(d[i], kk, spike_ofs);
    if (use_par) drive_bit(par_bit, kk, 0);
    drive_bit(stop_bit, kk, 0);
    rx = 1'b1;
  endtask

  // Counts clocks from the start-bit edge until rxrdy is seen high.
  int lat;
  logic lat_found;
  task automatic measure_latency(input int budget);
    lat_found = 1'b0;
    for (int c = 1; c <= budget && !lat_found; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rxrdy) begin
        lat_found = 1'b1;
        lat = c;
      end
    end
  endtask

  int nominal;
  logic lat_ok;
  logic [7:0] rd, exp_c3;
  int kk, nd, ones;
  logic e, p, o, par_ok, par_bit, stop_bit, corrupt;

  initial begin
    reset = 1'b0; rx = 1'b1; k = KW'(16); eight = 1'b1; pen = 1'b0; ohel = 1'b0; read = 1'b0;
    model_reset();
    idle(3);
    check_model("reset");
    reset = 1'b1;
    idle(20);

    // ---- 8N1 0xA5, latency ----
    nominal = SYNC + (16 >> 1) + 16 * 9 + 1;
    lat = nominal;
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16, 0);
      measure_latency(2000);
    join
    check("latency_found", {31'h0, lat_found}, 32'h1);
`ifdef RX_MAJORITY_VOTE_EN
    lat_ok = (lat >= nominal - 1) && (lat <= nominal + 2);
`else
    lat_ok = (lat >= nominal - 1) && (lat <= nominal + 1);
`endif
    $display("[TB] 8N1 0xA5 rxrdy latency %0d clocks (nominal %0d)", lat, nominal);
    check("latency_window", {31'h0, lat_ok}, 32'h1);
    if (!lat_found) lat = nominal;
    model_char(8'hA5, 1'b0, 1'b0);
    check_model("a5");
    pulse_read();
    check_model("a5_read");

    // ---- 7E1 parity ----
    eight = 1'b0; pen = 1'b1; ohel = 1'b0;
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 16, 0);
    idle(4);
    model_char(8'h41, 1'b0, 1'b0);
    check_model("par_good");
    $display("[TB] 7E1 0x41 good parity: data=%02h perr=%0b", rx_data, perr);
    pulse_read();
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 16, 0);
    idle(4);
    model_char(8'h41, 1'b1, 1'b0);
    check_model("par_bad");
    $display("[TB] 7E1 0x41 bad parity: data=%02h perr=%0b", rx_data, perr);
    pulse_read();
    eight = 1'b1; pen = 1'b0;

    // ---- framing error ----
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 16, 0);
    idle(4);
    model_char(8'h3C, 1'b0, 1'b1);
    check_model("ferr");
    $display("[TB] 0x3C stop=0: data=%02h ferr=%0b", rx_data, ferr);
    pulse_read();
    idle(32);

    // ---- break: 30 bit times low -> exactly one 0x00/ferr character ----
    rx = 1'b0;
    idle(30 * 16);
    model_char(8'h00, 1'b0, 1'b1);
    check_model("break");
    $display("[TB] break: data=%02h ferr=%0b ovf=%0b", rx_data, ferr, ovf);
    pulse_read();
    idle(5 * 16);
    check_model("break_hold");
    rx = 1'b1;
    idle(40);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 16, 0);
    idle(4);
    model_char(8'h55, 1'b0, 1'b0);
    check_model("after_break");
    pulse_read();

    // ---- back-to-back overrun ----
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 16, 0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 16, 0);
    idle(4);
    model_char(8'h11, 1'b0, 1'b0);
    model_char(8'h22, 1'b0, 1'b0);
    check_model("overrun");
    $display("[TB] 0x11,0x22 unread: data=%02h ovf=%0b", rx_data, ovf);
    pulse_read();

    // ---- read coinciding with done ----
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 16, 0);
    fork
      send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, 16, 0);
      begin
        repeat (lat - 1) @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
      end
    join
    model_reset();
    model_char(8'h44, 1'b0, 1'b0);
    check_model("read_on_done");
    $display("[TB] read on done clock: rxrdy=%0b ovf=%0b data=%02h", rxrdy, ovf, rx_data);
    pulse_read();

    // ---- short low glitch ----
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check_model("glitch");
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 16, 0);
    idle(4);
    model_char(8'h96, 1'b0, 1'b0);
    check_model("after_glitch");

    // ---- reset mid-DATA (rxrdy still set from 0x96) ----
    drive_bit(1'b0, 16, 0);
    drive_bit(1'b1, 16, 0);
    drive_bit(1'b0, 16, 0);
    rx = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    check_model("in_reset");
    idle(3);
    reset = 1'b1;
    idle(20);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16, 0);
    idle(4);
    model_char(8'h5A, 1'b0, 1'b0);
    check_model("after_reset");
    $display("[TB] reset mid-frame then 0x5A: data=%02h rxrdy=%0b", rx_data, rxrdy);
    pulse_read();

    // ---- one-clock spike at each data mid-bit ----
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 16, SYNC + (16 >> 1));
    idle(4);
`ifdef RX_MAJORITY_VOTE_EN
    exp_c3 = 8'hC3;
`else
    exp_c3 = 8'h3C;
`endif
    model_char(exp_c3, 1'b0, 1'b0);
    check_model("spike");
    $display("[TB] spiked 0xC3: data=%02h", rx_data);
    pulse_read();

    // ---- randomized frames ----
    for (int t = 0; t < 40; t++) begin
      kk = $urandom_range(4, 12);
      e  = 1'($urandom_range(0, 1));
      p  = 1'($urandom_range(0, 1));
      o  = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      nd = e ? 8 : 7;
      ones = 0;
      for (int i = 0; i < nd; i++) ones += int'(rd[i]);
      par_ok   = 1'(ones % 2) ^ o;
      corrupt  = ($urandom_range(0, 3) == 0);
      par_bit  = par_ok ^ corrupt;
      stop_bit = ($urandom_range(0, 3) != 0);
      k = KW'(kk); eight = e; pen = p; ohel = o;
      fork
        send_frame(rd, nd, p, par_bit, stop_bit, kk, 0);
        begin
          // Scramble config mid-frame; the engine must use the latched copy.
          repeat (2 * kk) @(posedge clk);
          #2;
          k = KW'($urandom_range(4, 40));
          eight = 1'($urandom_range(0, 1));
          pen = 1'($urandom_range(0, 1));
          ohel = 1'($urandom_range(0, 1));
        end
      join
      k = KW'(kk); eight = e; pen = p; ohel = o;
      idle(2 * kk);
      model_char(e ? rd : {1'b0, rd[6:0]}, p & corrupt, ~stop_bit);
      $display("[TB] rand %0d k=%0d eight=%0b pen=%0b ohel=%0b sent=%02h par=%0b stop=%0b -> data=%02h rdy=%0b perr=%0b ferr=%0b ovf=%0b",
               t, kk, e, p, o, rd, par_bit, stop_bit, rx_data, rxrdy, perr, ferr, ovf);
      check_model("rand");
      if ($urandom_range(0, 1) == 1) pulse_read();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
